// File: rtl/tb_error_collector_pkg.sv
// Shared constants, error-record type and parameter-check macro for the error collector.
`ifndef TB_STATIC_ASSERT
`define TB_STATIC_ASSERT(label, cond, msg) if (!(cond)) begin : label $error(msg); end
`endif

package tb_error_collector_pkg;

  localparam int unsigned TB_ERR_CODE_W_DFLT = 8;
  localparam int unsigned TB_ERR_SRC_MAX     = 16;

  typedef struct packed {
    logic [$clog2(TB_ERR_SRC_MAX)-1:0] src;
    logic [TB_ERR_CODE_W_DFLT-1:0]     code;
  } tb_err_rec_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/tb_error_collector_rr_arb.sv
// Round-robin arbiter: one-hot grant starting from a rotating priority pointer.
module tb_error_collector_rr_arb #(
  parameter int unsigned N_SRC = 4,
  localparam int unsigned SRC_W = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] gnt,
  output logic [SRC_W-1:0] gnt_idx
);

  logic [SRC_W-1:0] ptr;
  int unsigned      cand;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      cand = (32'(ptr) + off) % N_SRC;
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = SRC_W'(cand);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tb_error_collector.sv
// Collects error pulses from N sources into per-source slots, arbitrates them into
// a record FIFO drained over valid/ready, and keeps end-of-test statistics.
module tb_error_collector
  import tb_error_collector_pkg::*;
#(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned CODE_W = TB_ERR_CODE_W_DFLT,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned SRC_W = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        i_err_vld,
  input  logic [N_SRC*CODE_W-1:0] i_err_code,
  input  logic                    i_clr,
  output logic                    o_rpt_vld,
  output logic [SRC_W-1:0]        o_rpt_src,
  output logic [CODE_W-1:0]       o_rpt_code,
  input  logic                    i_rpt_rdy,
  output logic [CNT_W-1:0]        o_err_cnt,
  output logic [CNT_W-1:0]        o_drop_cnt,
  output logic                    o_first_vld,
  output logic [SRC_W-1:0]        o_first_src,
  output logic [CODE_W-1:0]       o_first_code,
  output logic                    o_ovf
);

  `TB_STATIC_ASSERT(g_chk_nsrc, N_SRC >= 2, "N_SRC must be at least 2")
  `TB_STATIC_ASSERT(g_chk_depth, is_pow2(DEPTH) && DEPTH >= 2, "DEPTH must be a power of two >= 2")

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [CODE_W-1:0] code;
  } rec_t;

  logic [N_SRC-1:0]  slot_vld;
  logic [CODE_W-1:0] slot_code [N_SRC];
  rec_t              mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic              pop, push, full, arb_en;
  logic [N_SRC-1:0]  gnt, load, drop;
  logic [SRC_W-1:0]  gnt_idx;
  logic [CNT_W:0]    err_sum, drop_sum;
  logic              any_pulse, any_drop, pick_found;
  logic [SRC_W-1:0]  pick_src;
  logic [CODE_W-1:0] pick_code;

  assign o_rpt_vld  = (count != '0);
  assign o_rpt_src  = mem[rd_ptr].src;
  assign o_rpt_code = mem[rd_ptr].code;

  assign pop    = o_rpt_vld & i_rpt_rdy;
  assign full   = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the full FIFO's slot, so the grant may proceed.
  assign arb_en = !full || pop;
  assign push   = |gnt;

  tb_error_collector_rr_arb #(.N_SRC(N_SRC)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (arb_en),
    .req     (slot_vld),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign load      = i_err_vld & (~slot_vld | gnt);
  assign drop      = i_err_vld & slot_vld & ~gnt;
  assign any_pulse = |i_err_vld;
  assign any_drop  = |drop;

  // Pulses in a clear cycle count as arriving after the clear.
  assign err_sum  = (i_clr ? '0 : {1'b0, o_err_cnt})  + (CNT_W+1)'($countones(i_err_vld));
  assign drop_sum = (i_clr ? '0 : {1'b0, o_drop_cnt}) + (CNT_W+1)'($countones(drop));

  always_comb begin
    pick_found = 1'b0;
    pick_src   = '0;
    pick_code  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!pick_found && i_err_vld[k]) begin
        pick_found = 1'b1;
        pick_src   = SRC_W'(k);
        pick_code  = i_err_code[k*CODE_W +: CODE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_err_cnt    <= '0;
      o_drop_cnt   <= '0;
      o_first_vld  <= 1'b0;
      o_first_src  <= '0;
      o_first_code <= '0;
      o_ovf        <= 1'b0;
      for (int unsigned k = 0; k < N_SRC; k++) slot_code[k] <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) mem[d] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_SRC; k++) begin
        if (load[k]) begin
          slot_vld[k]  <= 1'b1;
          slot_code[k] <= i_err_code[k*CODE_W +: CODE_W];
        end else if (gnt[k]) begin
          slot_vld[k]  <= 1'b0;
        end
      end

      if (push) begin
        mem[wr_ptr] <= '{src: gnt_idx, code: slot_code[gnt_idx]};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      o_err_cnt  <= err_sum[CNT_W]  ? '1 : err_sum[CNT_W-1:0];
      o_drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      o_ovf      <= (i_clr ? 1'b0 : o_ovf) | any_drop;

      if (any_pulse && (i_clr || !o_first_vld)) begin
        o_first_vld  <= 1'b1;
        o_first_src  <= pick_src;
        o_first_code <= pick_code;
      end else if (i_clr) begin
        o_first_vld  <= 1'b0;
      end
    end
  end

endmodule
